// File: rtl/pp_pkg.sv
// Shared ping-pong capture definitions used by the trigger writer and the reader.
package pp_pkg;

    localparam int unsigned PP_W  = 14;
    localparam int unsigned PP_AW = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_WAIT_TRIG,
        ST_POST,
        ST_HOLD
    } pp_state_t;

endpackage

// File: rtl/tgl_sync.sv
// Two-flop synchroniser for a toggle from another clock domain, plus a one-cycle
// pulse on every transition of the synchronised level.
module tgl_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic tgl,
    output logic pulse_c
);

    logic meta;
    logic sync;
    logic sync_d;

    // Synchroniser chain plus one delay stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= tgl;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign pulse_c = sync ^ sync_d;

endmodule

// File: rtl/pp_trig_writer.sv
// Triggered ping-pong capture writer: streams registered ADC samples into one half
// of a dual-half buffer, arms a trigger after the pre-trigger depth, finishes the
// frame after the post-trigger depth and hands the half over to the reader.
module pp_trig_writer
    import pp_pkg::*;
#(
    parameter int unsigned W         = PP_W,
    parameter int unsigned AW        = PP_AW,
    parameter int unsigned PRE_DEPTH = 256,
    parameter int unsigned AUTO_TO   = 65535
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [2*W-1:0] adc_data,
    input  logic [W-1:0]   trig_level,
    input  logic           trig_edge,
    input  logic           trig_auto,
    input  logic           arm,
    input  logic           rd_done_tgl,
    output logic           wr_en,
    output logic [AW:0]    wr_addr,
    output logic [2*W-1:0] wr_data,
    output logic           frame_tgl,
    output logic [AW-1:0]  trig_pos,
    output logic           frame_half,
    output logic           busy
);

    localparam int unsigned POST_DEPTH = (1 << AW) - PRE_DEPTH;
    localparam int unsigned ACW        = $clog2(AUTO_TO + 1);
    localparam bit          POST_ONE   = (POST_DEPTH == 1);

    pp_state_t           state;
    logic                half;
    logic                rd_half;
    logic [1:0]          full;
    logic [1:0]          full_free;
    logic [1:0]          full_d;
    logic [AW-1:0]       ptr;
    logic [AW-1:0]       cnt;
    logic [AW-1:0]       trig_ptr;
    logic [ACW-1:0]      auto_cnt;
    logic signed [W-1:0] cur_a;
    logic signed [W-1:0] prev_a;
    logic signed [W-1:0] level;
    logic                prev_valid;
    logic                rd_pulse;
    logic                free_c;
    logic                edge_hit;
    logic                trig_hit;
    logic                frame_done;

    tgl_sync u_rd_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .tgl     (rd_done_tgl),
        .pulse_c (rd_pulse)
    );

    assign wr_addr = {half, ptr};
    assign cur_a   = wr_data[2*W-1:W];
    assign level   = trig_level;

    // Edge detector on channel A of the registered sample.
    always_comb begin
        edge_hit = 1'b0;
        if (prev_valid) begin
            if (trig_edge) edge_hit = (prev_a > level) && (cur_a <= level);
            else           edge_hit = (prev_a < level) && (cur_a >= level);
        end
    end

    assign trig_hit   = (state == ST_WAIT_TRIG) &&
                        (edge_hit || (trig_auto && (auto_cnt == ACW'(AUTO_TO))));
    assign frame_done = ((state == ST_POST) && (cnt == AW'(POST_DEPTH - 1))) ||
                        (trig_hit && POST_ONE);

    // Half occupancy: reader free applied first, then the finishing frame marks its half.
    always_comb begin
        free_c    = rd_pulse && full[rd_half];
        full_free = full;
        if (free_c) full_free[rd_half] = 1'b0;
        full_d = full_free;
        if (frame_done) full_d[half] = 1'b1;
    end

    // Input sample register feeding both the buffer and the trigger compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wr_data <= '0;
        else        wr_data <= adc_data;
    end

    // Capture FSM with registered write strobe, busy and frame hand-off outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            half       <= 1'b0;
            rd_half    <= 1'b0;
            full       <= 2'b00;
            ptr        <= '0;
            cnt        <= '0;
            trig_ptr   <= '0;
            auto_cnt   <= '0;
            prev_a     <= '0;
            prev_valid <= 1'b0;
            wr_en      <= 1'b0;
            busy       <= 1'b0;
            frame_tgl  <= 1'b0;
            trig_pos   <= '0;
            frame_half <= 1'b0;
        end else begin
            full <= full_d;
            if (free_c) rd_half <= ~rd_half;
            if (wr_en) begin
                prev_a     <= cur_a;
                prev_valid <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (arm && !full_free[half]) begin
                        state      <= ST_PRE;
                        wr_en      <= 1'b1;
                        busy       <= 1'b1;
                        ptr        <= '0;
                        cnt        <= '0;
                        prev_valid <= 1'b0;
                    end
                end
                ST_PRE: begin
                    ptr <= ptr + 1'b1;
                    if (cnt == AW'(PRE_DEPTH - 1)) begin
                        state <= ST_WAIT_TRIG;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT_TRIG: begin
                    ptr <= ptr + 1'b1;
                    if (trig_hit) begin
                        state    <= ST_POST;
                        trig_ptr <= ptr;
                        cnt      <= AW'(1);
                        auto_cnt <= '0;
                    end else if (trig_auto) begin
                        auto_cnt <= auto_cnt + 1'b1;
                    end
                end
                ST_POST: begin
                    ptr <= ptr + 1'b1;
                    cnt <= cnt + 1'b1;
                end
                ST_HOLD: begin
                    if (!arm) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (!full_free[half]) begin
                        state <= ST_PRE;
                        wr_en <= 1'b1;
                        ptr   <= '0;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    wr_en <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase

            // Frame hand-off: publish the frame and move to the other half.
            if (frame_done) begin
                frame_tgl  <= ~frame_tgl;
                frame_half <= half;
                trig_pos   <= (state == ST_WAIT_TRIG) ? ptr : trig_ptr;
                half       <= ~half;
                ptr        <= '0;
                cnt        <= '0;
                auto_cnt   <= '0;
                if (!arm) begin
                    state <= ST_IDLE;
                    wr_en <= 1'b0;
                    busy  <= 1'b0;
                end else if (full_d[~half]) begin
                    state <= ST_HOLD;
                    wr_en <= 1'b0;
                    busy  <= 1'b1;
                end else begin
                    state <= ST_PRE;
                    wr_en <= 1'b1;
                    busy  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pp_trig_writer.sv
// Directed bench for the triggered ping-pong writer (AW=10, PRE_DEPTH=256, AUTO_TO=1000).
module tb_pp_trig_writer;

    logic        clk;
    logic        rst_n;
    logic [27:0] adc_data;
    logic [13:0] trig_level;
    logic        trig_edge;
    logic        trig_auto;
    logic        arm;
    logic        rd_done_tgl;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [27:0] wr_data;
    logic        frame_tgl;
    logic [9:0]  trig_pos;
    logic        frame_half;
    logic        busy;

    int   n_cmp;
    int   n_bad;
    int   done_at;
    logic gap;

    pp_trig_writer #(
        .W         (14),
        .AW        (10),
        .PRE_DEPTH (256),
        .AUTO_TO   (1000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .adc_data    (adc_data),
        .trig_level  (trig_level),
        .trig_edge   (trig_edge),
        .trig_auto   (trig_auto),
        .arm         (arm),
        .rd_done_tgl (rd_done_tgl),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .frame_tgl   (frame_tgl),
        .trig_pos    (trig_pos),
        .frame_half  (frame_half),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sawtooth -100..+100, one step per sample.
    function automatic logic [13:0] ramp(input int j);
        int v;
        v = -100 + (j % 201);
        return 14'(v);
    endfunction

    // Falling sawtooth +50..-50, phased so WAIT_TRIG opens near the bottom.
    function automatic logic [13:0] fall(input int j);
        int v;
        v = 50 - ((j + 41) % 101);
        return 14'(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        rst_n       = 1'b0;
        arm         = 1'b0;
        adc_data    = '0;
        trig_level  = '0;
        trig_edge   = 1'b0;
        trig_auto   = 1'b0;
        rd_done_tgl = 1'b0;
        gap         = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst_wr_en",      32'(wr_en),      0);
        chk("rst_wr_addr",    32'(wr_addr),    0);
        chk("rst_wr_data",    32'(wr_data),    0);
        chk("rst_frame_tgl",  32'(frame_tgl),  0);
        chk("rst_trig_pos",   32'(trig_pos),   0);
        chk("rst_frame_half", 32'(frame_half), 0);
        chk("rst_busy",       32'(busy),       0);
        rst_n = 1'b1;
        step();
        chk("idle_busy", 32'(busy), 0);

        // Frame 1: rising ramp, level 0, half 0
        arm     = 1'b1;
        done_at = -1;
        for (int i = 0; i < 1500; i++) begin
            adc_data = {ramp(i), 14'(i)};
            step();
            if (i == 0) begin
                chk("f1_first_wr_en", 32'(wr_en),   1);
                chk("f1_first_addr",  32'(wr_addr), 0);
                chk("f1_first_data",  32'(wr_data), 32'({ramp(0), 14'(0)}));
            end
            if (i == 1068) chk("f1_last_addr", 32'(wr_addr), 44);
            if (frame_tgl) begin
                done_at = i;
                break;
            end
        end
        chk("f1_done_at",   32'(done_at),    1069);
        chk("f1_trig_pos",  32'(trig_pos),   301);
        chk("f1_half",      32'(frame_half), 0);
        chk("f1_next_en",   32'(wr_en),      1);
        chk("f1_next_addr", 32'(wr_addr),    1024);
        chk("f1_next_data", 32'(wr_data),    32'({ramp(1069), 14'(1069)}));

        // Frame 2: falling edge at -10 on half 1; rising crossing must be ignored
        trig_edge  = 1'b1;
        trig_level = 14'(-10);
        done_at    = -1;
        for (int j = 1; j < 1500; j++) begin
            adc_data = {fall(j), 14'(j)};
            step();
            if (!frame_tgl) begin
                done_at = j;
                break;
            end
        end
        chk("f2_done_at",  32'(done_at),    1090);
        chk("f2_trig_pos", 32'(trig_pos),   322);
        chk("f2_half",     32'(frame_half), 1);
        chk("f2_hold_en",  32'(wr_en),      0);
        chk("f2_hold_bsy", 32'(busy),       1);

        // HOLD until the reader frees half 0
        trig_edge  = 1'b0;
        trig_level = '0;
        adc_data   = {ramp(0), 14'(0)};
        repeat (5) step();
        chk("hold_wr_en", 32'(wr_en), 0);
        rd_done_tgl = 1'b1;
        step();
        chk("hold_sync1_en", 32'(wr_en), 0);
        step();
        chk("hold_sync2_en", 32'(wr_en), 0);
        step();
        chk("hold_exit_en",   32'(wr_en),   1);
        chk("hold_exit_addr", 32'(wr_addr), 0);

        // Frame 3: free of half 1 lands on the frame-done cycle
        done_at = -1;
        for (int j = 1; j < 1500; j++) begin
            if (j == 1067) rd_done_tgl = 1'b0;
            adc_data = {ramp(j), 14'(j)};
            step();
            if (frame_tgl) begin
                done_at = j;
                break;
            end
            if (!wr_en) gap = 1'b1;
        end
        chk("f3_done_at",   32'(done_at),    1069);
        chk("f3_trig_pos",  32'(trig_pos),   301);
        chk("f3_half",      32'(frame_half), 0);
        chk("f3_gap",       32'(gap),        0);
        chk("f3_next_en",   32'(wr_en),      1);
        chk("f3_next_addr", 32'(wr_addr),    1024);

        // Frame 4: constant channel A, auto trigger after 1000 cycles in WAIT_TRIG
        trig_auto = 1'b1;
        done_at   = -1;
        for (int j = 1; j < 3000; j++) begin
            adc_data = {14'(5), 14'(j)};
            step();
            if (!frame_tgl) begin
                done_at = j;
                break;
            end
        end
        chk("f4_done_at",  32'(done_at),    2024);
        chk("f4_trig_pos", 32'(trig_pos),   232);
        chk("f4_half",     32'(frame_half), 1);
        chk("f4_hold_en",  32'(wr_en),      0);

        // Disarm in HOLD, free half 0, then re-arm without auto: no frame
        arm = 1'b0;
        step();
        chk("disarm_busy", 32'(busy), 0);
        rd_done_tgl = 1'b1;
        repeat (4) step();
        arm       = 1'b1;
        trig_auto = 1'b0;
        for (int j = 0; j < 2000; j++) begin
            adc_data = {14'(5), 14'(j)};
            step();
        end
        chk("noauto_tgl",  32'(frame_tgl), 0);
        chk("noauto_en",   32'(wr_en),     1);
        chk("noauto_busy", 32'(busy),      1);

        // Force a rising edge into POST, then reset mid-frame
        adc_data = {14'(-5), 14'(0)};
        step();
        adc_data = {14'(5), 14'(1)};
        repeat (10) step();
        chk("post_en", 32'(wr_en), 1);
        rst_n = 1'b0;
        #1;
        chk("mrst_wr_en",   32'(wr_en),      0);
        chk("mrst_busy",    32'(busy),       0);
        chk("mrst_addr",    32'(wr_addr),    0);
        chk("mrst_data",    32'(wr_data),    0);
        chk("mrst_tgl",     32'(frame_tgl),  0);
        chk("mrst_pos",     32'(trig_pos),   0);
        chk("mrst_half",    32'(frame_half), 0);
        arm = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (20) step();
        chk("after_rst_tgl",  32'(frame_tgl), 0);
        chk("after_rst_busy", 32'(busy),      0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pp_trig_writer.md
PP_TRIG_WRITER -- requirements
Module: pp_trig_writer

Interface
REQ-001 SHALL have parameter W, default 14, the per-channel sample width.
REQ-002 SHALL have parameter AW, default 10, the half-buffer address width.
REQ-003 SHALL have parameter PRE_DEPTH, default 256, the pre-trigger samples per frame; legal range 1..2^AW-1.
REQ-004 SHALL have parameter AUTO_TO, default 65535, the auto-trigger timeout in clk cycles.
REQ-005 clk  in  1  ADC-domain clock; the only clock; all logic on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 adc_data  in  2W  packed sample; channel A = [2W-1:W], channel B = [W-1:0].
REQ-008 trig_level  in  W  signed threshold on channel A.
REQ-009 trig_edge  in  1  0 = rising, 1 = falling.
REQ-010 trig_auto  in  1  1 = force a trigger after AUTO_TO cycles without an edge.
REQ-011 arm  in  1  level; 1 = capture continuously, 0 = stop after the current frame.
REQ-012 rd_done_tgl  in  1  reader-domain toggle; each transition frees one half.
REQ-013 wr_en  out  1  BRAM write strobe.
REQ-014 wr_addr  out  AW+1  {half, ptr}.
REQ-015 wr_data  out  2W  registered adc_data.
REQ-016 frame_tgl  out  1  toggles once per completed frame.
REQ-017 trig_pos  out  AW  ptr of the trigger sample of the last completed frame.
REQ-018 frame_half  out  1  half holding the last completed frame.
REQ-019 busy  out  1  high in any state other than IDLE.

Function
REQ-020 adc_data SHALL be registered once; wr_data, wr_en and the trigger compare SHALL all use the registered sample (1-cycle latency).
REQ-021 States: IDLE, PRE, WAIT_TRIG, POST, HOLD.
- IDLE -> PRE when arm=1 and the current half is free.
- PRE -> WAIT_TRIG after PRE_DEPTH writes.
- WAIT_TRIG -> POST on a trigger.
- POST -> frame done after 2^AW - PRE_DEPTH writes, counting the trigger sample.
REQ-022 wr_en SHALL be 1 in PRE, WAIT_TRIG and POST, and 0 in IDLE and HOLD; ptr SHALL increment per write and wrap from 2^AW-1 to 0 within the half.
REQ-023 Rising trigger SHALL be prev_A < trig_level and cur_A >= trig_level (signed); falling trigger SHALL be prev_A > trig_level and cur_A <= trig_level.
REQ-024 An edge SHALL be evaluated only in WAIT_TRIG; edges seen in PRE SHALL be ignored; prev_A SHALL be invalid on the first sample after IDLE.
REQ-025 When trig_auto=1, a counter SHALL run in WAIT_TRIG; reaching AUTO_TO SHALL force a trigger on the current sample; the counter SHALL clear on leaving WAIT_TRIG.
REQ-026 trig_pos SHALL latch the ptr of the trigger sample; it, frame_half and frame_tgl SHALL update together on frame done.
REQ-027 On frame done, the current half SHALL be marked full.
- If arm=1 and the other half is free: switch halves, reset ptr to 0, go to PRE.
- If arm=1 and the other half is full: go to HOLD.
- If arm=0: go to IDLE.
REQ-028 rd_done_tgl SHALL pass through a 2-FF synchroniser; each detected edge SHALL free the oldest full half (rd_half pointer, then flip rd_half).
- An edge with no full half SHALL be ignored.
REQ-029 HOLD SHALL leave to PRE on the other half in the cycle after a free is registered.
- If arm=0 while in HOLD, HOLD SHALL go to IDLE.
REQ-030 A free and a frame done in the same cycle SHALL both apply; the free is evaluated first.

Reset
REQ-031 On rst_n=0, outputs SHALL reset as follows:
- state=IDLE, both halves free, current half=0, rd_half=0, ptr=0.
- wr_en=0, wr_addr=0, wr_data=0, frame_tgl=0, trig_pos=0, frame_half=0, busy=0.
- Synchroniser flops SHALL be 0.
REQ-032 Reset mid-frame SHALL discard the partial frame and SHALL NOT toggle frame_tgl.

Structure
REQ-033 Shared package pp_pkg SHALL hold the state enum and the W/AW defaults shared with the ping-pong reader.
REQ-034 One sub-module, tgl_sync (2-FF synchroniser plus edge pulse), SHALL be instantiated for rd_done_tgl.

Verification (AW=10, PRE_DEPTH=256 unless noted)
REQ-035 Channel A ramp -100..+100 step 1, level 0, rising, arm=1 -> trigger on sample value 0; 768 post writes; frame_tgl toggles once; trig_pos = ptr of the value-0 sample.
REQ-036 Falling edge, channel A ramp +50..-50, level -10 -> trigger on sample value -10; rising-only crossings produce no trigger.
REQ-037 Constant channel A, trig_auto=1, AUTO_TO=1000 -> trigger forced exactly 1000 cycles after entering WAIT_TRIG; trig_auto=0 -> no frame.
REQ-038 No rd_done_tgl edge after two frames -> HOLD with wr_en=0; one toggle -> PRE on half 0 on the next cycle.
REQ-039 rd_done_tgl edge arrives in the frame-done cycle with half 1 full -> no HOLD; capture continues seamlessly.
REQ-040 rst_n pulsed during POST -> all outputs at reset values immediately; no frame_tgl edge.
